sdspi_saver: RTL and testbench

- APB initiator that copies a contiguous region of main memory onto consecutive microSD sectors through the SD SPI controller's APB slave. It is the write-direction counterpart of the boot loader.
- Per sector it fetches 32-bit words from the memory controller, pushes them bytewise into the controller's block buffer, then triggers a sector write and waits for completion.
- It sits beside the memory controller and the SD controller, and is started by a one-cycle pulse from main init/debug logic.

---
 rtl/sdspi_saver.sv | 249 ++++++++++++++++++++++++
 tb/tb_sdspi_saver.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdspi_saver.sv
// Copies a contiguous main-memory region onto consecutive microSD sectors.
// It fetches 32-bit words, writes them one byte at a time over APB, then triggers a sector write.
module sdspi_saver #(
    parameter logic [15:0] BLOCKADDR    = 16'h0200,
    parameter int unsigned BLOCKSIZE    = 512,
    parameter logic [15:0] WRTRIG_ADDR  = 16'h0008,
    parameter logic [31:0] SAVE_SIZE    = 32'h0010_0000,
    parameter logic [31:0] MEM_BASE     = 32'h0,
    parameter logic [31:0] START_SECTOR = 32'd0
) (
    input  logic        clk27mhz,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] sdspi_status,
    input  logic        sdsbusy,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [15:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr,
    input  logic [7:0]  w_ctrl_state,
    output logic        RE,
    output logic [31:0] ADDR,
    input  logic [31:0] RDATA,
    input  logic        RVALID,
    output logic [7:0]  w_saver_state,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    localparam logic [31:0] BLOCK_BYTES = BLOCKSIZE;

    typedef enum logic [7:0] {
        S_IDLE  = 8'd0,
        S_FETCH = 8'd10,
        S_FWAIT = 8'd11,
        S_BSET  = 8'd20,
        S_BACC  = 8'd21,
        S_TSET  = 8'd30,
        S_TACC  = 8'd31,
        S_WRISE = 8'd32,
        S_WFALL = 8'd33
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] sector_q, sector_d;
    logic [31:0] boff_q, boff_d;
    logic [31:0] total_q, total_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  k_q, k_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [15:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        re_q, re_d;
    logic [31:0] addr_q, addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        sd_idle;
    logic [7:0]  cur_byte;
    logic        unused_inputs;

    assign sd_idle       = !sdsbusy && (sdspi_status[15:0] == 16'h0000);
    assign cur_byte      = word_q[{k_q, 3'b000} +: 8];
    assign unused_inputs = ^{prdata, sdspi_status[31:16]};

    // NOTE: every _d gets its current value first, so no path through the case can infer a latch.
    always_comb begin
        state_d   = state_q;
        sector_d  = sector_q;
        boff_d    = boff_q;
        total_d   = total_q;
        word_d    = word_q;
        k_d       = k_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        re_d      = re_q;
        addr_d    = addr_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (start && !done_q && !err_q && sd_idle) begin
                    busy_d   = 1'b1;
                    sector_d = START_SECTOR;
                    boff_d   = 32'd0;
                    total_d  = 32'd0;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_ctrl_state == 8'd0) begin
                    re_d    = 1'b1;
                    addr_d  = MEM_BASE + total_q;
                    state_d = S_FWAIT;
                end
            end
            S_FWAIT: begin
                if (w_ctrl_state != 8'd0) re_d = 1'b0;
                if (RVALID) begin
                    re_d    = 1'b0;
                    word_d  = RDATA;
                    k_d     = 2'd0;
                    state_d = S_BSET;
                end
            end
            S_BSET: begin
                psel_d    = 1'b1;
                penable_d = 1'b0;
                pwrite_d  = 1'b1;
                paddr_d   = BLOCKADDR + boff_q[15:0];
                pwdata_d  = {24'h0, cur_byte};
                state_d   = S_BACC;
            end
            S_BACC: begin
                if (!penable_q) begin
                    penable_d = 1'b1;
                end else if (pready) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b0;
                    if (pslverr) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        boff_d  = boff_q + 32'd1;
                        total_d = total_q + 32'd1;
                        k_d     = k_q + 2'd1;
                        // Sector ends on a full buffer or on the last saved byte.
                        if (k_q != 2'd3)
                            state_d = S_BSET;
                        else if (((boff_q + 32'd1) == BLOCK_BYTES) || ((total_q + 32'd1) == SAVE_SIZE))
                            state_d = S_TSET;
                        else
                            state_d = S_FETCH;
                    end
                end
            end
            S_TSET: begin
                if (sd_idle) begin
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b1;
                    paddr_d   = WRTRIG_ADDR;
                    pwdata_d  = sector_q;
                    state_d   = S_TACC;
                end
            end
            S_TACC: begin
                if (!penable_q) begin
                    penable_d = 1'b1;
                end else if (pready) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b0;
                    if (pslverr) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WRISE;
                    end
                end
            end
            S_WRISE: begin
                if (sdsbusy) state_d = S_WFALL;
            end
            S_WFALL: begin
                if (sd_idle) begin
                    sector_d = sector_q + 32'd1;
                    boff_d   = 32'd0;
                    if (total_q == SAVE_SIZE) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk27mhz) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            sector_q  <= START_SECTOR;
            boff_q    <= 32'd0;
            total_q   <= 32'd0;
            word_q    <= 32'd0;
            k_q       <= 2'd0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= 16'd0;
            pwdata_q  <= 32'd0;
            re_q      <= 1'b0;
            addr_q    <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sector_q  <= sector_d;
            boff_q    <= boff_d;
            total_q   <= total_d;
            word_q    <= word_d;
            k_q       <= k_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            re_q      <= re_d;
            addr_q    <= addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign psel          = psel_q;
    assign penable       = penable_q;
    assign pwrite        = pwrite_q;
    assign paddr         = paddr_q;
    assign pwdata        = pwdata_q;
    assign RE            = re_q;
    assign ADDR          = addr_q;
    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign ERR           = err_q;
    assign w_saver_state = state_q;

endmodule

// File: tb/tb_sdspi_saver.sv
// Directed bench for sdspi_saver: memory, APB slave and SD busy models plus a linear check sequence.
// Memory byte at offset o from MEM_BASE is ((o+1)*17)[7:0] ^ o[15:8], so word 0 is 32'h44332211.
module tb_sdspi_saver;

    localparam logic [15:0] BLOCKADDR = 16'h0200;
    localparam logic [15:0] WRTRIG    = 16'h0008;
    localparam int          BLK       = 512;
    localparam int          SAVE      = 1028;
    localparam logic [31:0] MEMBASE   = 32'h0000_1000;
    localparam logic [31:0] STARTSEC  = 32'd5;

    logic        clk27mhz = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] sdspi_status = 32'd0;
    logic        sd_force = 1'b0;
    logic        sd_model_busy = 1'b0;
    logic        sdsbusy;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata = 32'd0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;
    logic [7:0]  w_ctrl_state = 8'd0;
    logic        RE;
    logic [31:0] ADDR;
    logic [31:0] RDATA = 32'd0;
    logic        RVALID = 1'b0;
    logic [7:0]  w_saver_state;
    logic        BUSY, DONE, ERR;

    assign sdsbusy = sd_model_busy | sd_force;

    sdspi_saver #(
        .BLOCKADDR(BLOCKADDR), .BLOCKSIZE(BLK), .WRTRIG_ADDR(WRTRIG),
        .SAVE_SIZE(SAVE), .MEM_BASE(MEMBASE), .START_SECTOR(STARTSEC)
    ) dut (
        .clk27mhz(clk27mhz), .resetn(resetn), .start(start),
        .sdspi_status(sdspi_status), .sdsbusy(sdsbusy),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .w_ctrl_state(w_ctrl_state), .RE(RE), .ADDR(ADDR), .RDATA(RDATA),
        .RVALID(RVALID), .w_saver_state(w_saver_state),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    initial forever #5 clk27mhz = ~clk27mhz;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] off);
        logic [31:0] p;
        p = (off + 32'd1) * 32'd17;
        return p[7:0] ^ off[15:8];
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] o;
        o = a - MEMBASE;
        return {mem_byte(o + 32'd3), mem_byte(o + 32'd2), mem_byte(o + 32'd1), mem_byte(o)};
    endfunction

    // Observation logs written only by the models.
    logic [15:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [31:0] re_addr[$];
    int          trig_total = 0;
    int          stab_errs = 0;
    int          proto_errs = 0;
    int          waitstates = 0;
    int          err_at = 0;

    // APB slave: checks SETUP-before-ACCESS and stability, logs each completed write.
    initial begin : apb_slave
        int          wcnt;
        logic        su_seen;
        logic [15:0] su_addr;
        logic [31:0] su_data;
        wcnt = 0;
        su_seen = 1'b0;
        su_addr = 16'd0;
        su_data = 32'd0;
        forever begin
            @(posedge clk27mhz); #1;
            if (psel === 1'b1 && penable === 1'b0) begin
                su_addr = paddr;
                su_data = pwdata;
                su_seen = 1'b1;
                pready  = 1'b0;
                pslverr = 1'b0;
                wcnt    = 0;
            end else if (psel === 1'b1 && penable === 1'b1) begin
                if (!su_seen) proto_errs++;
                if (paddr !== su_addr || pwdata !== su_data || pwrite !== 1'b1) stab_errs++;
                if (pready) begin
                    proto_errs++;
                    pready  = 1'b0;
                    pslverr = 1'b0;
                end else if (wcnt < waitstates) begin
                    wcnt++;
                end else begin
                    pready = 1'b1;
                    log_addr.push_back(paddr);
                    log_data.push_back(pwdata);
                    if (paddr == WRTRIG) trig_total++;
                    if (err_at != 0 && log_addr.size() == err_at) pslverr = 1'b1;
                    su_seen = 1'b0;
                end
            end else begin
                pready  = 1'b0;
                pslverr = 1'b0;
                su_seen = 1'b0;
                wcnt    = 0;
            end
        end
    end

    // Memory controller: busy one cycle after RE, data strobe the cycle after.
    initial begin : mem_model
        logic [31:0] a;
        forever begin
            @(posedge clk27mhz); #1;
            if (RE === 1'b1 && w_ctrl_state == 8'd0) begin
                a = ADDR;
                re_addr.push_back(a);
                w_ctrl_state = 8'd3;
                @(posedge clk27mhz); #1;
                RVALID = 1'b1;
                RDATA  = mem_word(a);
                @(posedge clk27mhz); #1;
                RVALID = 1'b0;
                RDATA  = 32'd0;
                w_ctrl_state = 8'd0;
            end
        end
    end

    // SD controller: a 5-cycle busy pulse two cycles after each trigger write.
    initial begin : sd_model
        int seen;
        seen = 0;
        forever begin
            @(posedge clk27mhz); #1;
            if (trig_total != seen) begin
                seen = trig_total;
                repeat (2) @(posedge clk27mhz);
                #1 sd_model_busy = 1'b1;
                repeat (5) @(posedge clk27mhz);
                #1 sd_model_busy = 1'b0;
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk27mhz); #1;
        start = 1'b0;
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_apb"}, {13'd0, psel, penable, pwrite, paddr, pwdata}, 64'd0);
        check({pfx, "_mem"}, {31'd0, RE, ADDR}, 64'd0);
        check({pfx, "_flags"}, {53'd0, BUSY, DONE, ERR, w_saver_state}, 64'd0);
    endtask

    int cyc;
    int base_log;
    int base_re;
    int base_trig;
    int seq_errs;
    int idx;
    int nb;
    int trig_found;
    logic [31:0] trig_vals[$];

    initial begin
        // Reset state
        resetn = 1'b0;
        repeat (3) @(posedge clk27mhz);
        #1;
        check_outputs_zero("reset");
        resetn = 1'b1;
        @(posedge clk27mhz); #1;

        // Start gating: SD busy, then SD status non-idle
        sd_force = 1'b1;
        pulse_start();
        repeat (3) @(posedge clk27mhz);
        #1;
        check("gate_busy_BUSY", {63'd0, BUSY}, 64'd0);
        check("gate_busy_state", {56'd0, w_saver_state}, 64'd0);
        sd_force = 1'b0;
        sdspi_status = 32'h0000_0100;
        pulse_start();
        repeat (3) @(posedge clk27mhz);
        #1;
        check("gate_status_BUSY", {63'd0, BUSY}, 64'd0);
        check("gate_no_fetch", re_addr.size(), 64'd0);
        sdspi_status = 32'd0;

        // Full save with three APB wait states per access
        waitstates = 3;
        pulse_start();
        check("start_BUSY", {63'd0, BUSY}, 64'd1);
        check("start_state", {56'd0, w_saver_state}, 64'd10);
        cyc = 0;
        while (DONE !== 1'b1 && cyc < 40000) begin
            @(posedge clk27mhz); #1;
            cyc++;
        end
        check("done_in_time", {63'd0, cyc < 40000}, 64'd1);
        check("done_flags", {53'd0, BUSY, DONE, ERR, w_saver_state}, {53'd0, 3'b010, 8'd0});
        check("xfer_count", log_addr.size(), 64'd1031);
        check("re_count", re_addr.size(), 64'd257);
        if (re_addr.size() >= 257) begin
            check("re_first_addr", re_addr[0], 64'h1000);
            check("re_last_addr", re_addr[256], 64'h1400);
        end
        if (log_addr.size() >= 1031) begin
            check("b0_addr", log_addr[0], 64'h0200);
            check("b0_data", log_data[0], 64'h11);
            check("b1_data", log_data[1], 64'h22);
            check("b2_data", log_data[2], 64'h33);
            check("b3_addr", log_addr[3], 64'h0203);
            check("b3_data", log_data[3], 64'h44);
            check("tail_last_addr", log_addr[1029], 64'h0203);
            check("tail_trig_addr", log_addr[1030], 64'h0008);
        end
        trig_vals.delete();
        foreach (log_addr[i]) if (log_addr[i] == WRTRIG) trig_vals.push_back(log_data[i]);
        trig_found = trig_vals.size();
        check("trig_count", trig_found, 64'd3);
        if (trig_found == 3) begin
            check("trig_sector0", trig_vals[0], 64'd5);
            check("trig_sector1", trig_vals[1], 64'd6);
            check("trig_sector2", trig_vals[2], 64'd7);
        end
        seq_errs = 0;
        idx = 0;
        for (int sec = 0; sec < 3; sec++) begin
            nb = (SAVE - sec * BLK) > BLK ? BLK : (SAVE - sec * BLK);
            for (int i = 0; i < nb; i++) begin
                if (idx >= log_addr.size()) seq_errs++;
                else if (log_addr[idx] !== BLOCKADDR + 16'(i) ||
                         log_data[idx] !== {24'd0, mem_byte(32'(sec * BLK + i))}) seq_errs++;
                idx++;
            end
            if (idx >= log_addr.size()) seq_errs++;
            else if (log_addr[idx] !== WRTRIG || log_data[idx] !== STARTSEC + 32'(sec)) seq_errs++;
            idx++;
        end
        check("byte_sequence_errs", seq_errs, 64'd0);
        check("apb_stability_errs", stab_errs, 64'd0);
        check("apb_protocol_errs", proto_errs, 64'd0);

        // Start after DONE is ignored
        base_log = log_addr.size();
        base_re = re_addr.size();
        pulse_start();
        repeat (10) @(posedge clk27mhz);
        #1;
        check("restart_after_done_BUSY", {63'd0, BUSY}, 64'd0);
        check("restart_after_done_xfers", log_addr.size() - base_log, 64'd0);
        check("restart_after_done_fetch", re_addr.size() - base_re, 64'd0);

        // pslverr on the 10th byte write
        resetn = 1'b0;
        @(posedge clk27mhz); #1;
        resetn = 1'b1;
        waitstates = 0;
        base_log = log_addr.size();
        base_trig = trig_total;
        err_at = base_log + 10;
        pulse_start();
        cyc = 0;
        while (ERR !== 1'b1 && cyc < 5000) begin
            @(posedge clk27mhz); #1;
            cyc++;
        end
        err_at = 0;
        check("err_in_time", {63'd0, cyc < 5000}, 64'd1);
        check("err_flags", {53'd0, BUSY, DONE, ERR, w_saver_state}, {53'd0, 3'b001, 8'd0});
        repeat (10) @(posedge clk27mhz);
        #1;
        check("err_xfer_count", log_addr.size() - base_log, 64'd10);
        check("err_no_trigger", trig_total - base_trig, 64'd0);
        check("err_psel_low", {63'd0, psel}, 64'd0);

        // Reset while waiting for the sector write to finish
        resetn = 1'b0;
        @(posedge clk27mhz); #1;
        resetn = 1'b1;
        pulse_start();
        cyc = 0;
        while (w_saver_state !== 8'd33 && cyc < 10000) begin
            @(posedge clk27mhz); #1;
            cyc++;
        end
        check("wfall_in_time", {63'd0, cyc < 10000}, 64'd1);
        resetn = 1'b0;
        @(posedge clk27mhz); #1;
        check_outputs_zero("midreset");
        resetn = 1'b1;
        cyc = 0;
        while (sdsbusy !== 1'b0 && cyc < 100) begin
            @(posedge clk27mhz); #1;
            cyc++;
        end
        base_log = log_addr.size();
        base_re = re_addr.size();
        base_trig = trig_total;
        pulse_start();
        cyc = 0;
        while (trig_total == base_trig && cyc < 10000) begin
            @(posedge clk27mhz); #1;
            cyc++;
        end
        check("rerun_trig_in_time", {63'd0, cyc < 10000}, 64'd1);
        if (re_addr.size() > base_re) check("rerun_first_fetch", re_addr[base_re], 64'h1000);
        else check("rerun_first_fetch_seen", re_addr.size() - base_re, 64'd1);
        if (log_addr.size() >= base_log + 513) begin
            check("rerun_b0_addr", log_addr[base_log], 64'h0200);
            check("rerun_b0_data", log_data[base_log], 64'h11);
            check("rerun_trig_addr", log_addr[base_log + 512], 64'h0008);
            check("rerun_trig_sector", log_data[base_log + 512], 64'd5);
        end else begin
            check("rerun_xfer_count", log_addr.size() - base_log, 64'd513);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
